instr_seq_ctrl: RTL and testbench

//  Fetch/decode sequencer for the 8-bit execute stage. Fetches 24-bit words from instruction memory.

---
 rtl/instr_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_instr_seq_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: fetch/decode sequencer for the 8-bit execute stage.
// Ports:
//   clk, reset (async, active low)
//   imem_req/imem_addr/imem_data/imem_valid : instruction fetch
//   flag_ex : {parity,ovf,zero,carry} feedback
//   op_dec/RW_dec/imm_dec/b_sel_imm/mem_* : execute controls
//   dec_valid/halted/ill_op : status
// Option: define SEQ_CALL_STACK_EN for the CALL/RET stack.
module instr_seq_ctrl #(
  parameter int PC_W     = 8,
  parameter int MEM_WAIT = 2,
  parameter int STK_D    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [23:0]     imem_data,
  input  logic            imem_valid,
  input  logic [3:0]      flag_ex,
  output logic [4:0]      op_dec,
  output logic [4:0]      RW_dec,
  output logic [7:0]      imm_dec,
  output logic            b_sel_imm,
  output logic            mem_en_dec,
  output logic            mem_rw_dec,
  output logic            mem_mux_sel_dec,
  output logic            dec_valid,
  output logic            halted,
  output logic            ill_op
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_BUB  = 5'b11000;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_JC   = 5'b11100;
  localparam logic [4:0] OP_JNC  = 5'b11101;
  localparam logic [4:0] OP_JZ   = 5'b11110;
  localparam logic [4:0] OP_JNZ  = 5'b11111;
  localparam logic [4:0] OP_LD   = 5'b10100;
  localparam logic [4:0] OP_ST   = 5'b10101;
  localparam logic [4:0] OP_HLT  = 5'b10001;
  localparam logic [4:0] OP_CALL = 5'b10010;
  localparam logic [4:0] OP_RET  = 5'b10000;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc, tgt;
  logic [23:0]     ir;
  logic [3:0]      wcnt, wcnt_n;
  logic [4:0]      op;

  logic is_ld, is_st, is_hlt, is_call, is_ret;
  logic is_br, is_bad, is_bub, taken;
  logic call_tk, ret_tk, ret_ill;
  logic [PC_W-1:0] ret_pc;

  logic [4:0] d_op, d_rw;
  logic [7:0] d_imm;
  logic       d_bsel, d_men, d_mrw, d_mmux;

  logic unused_ok;
  assign unused_ok = ^{ir[13:8], flag_ex[3:2]};

  assign op        = ir[23:19];
  assign pc_inc    = pc + 1'b1;
  assign tgt       = PC_W'(ir[7:0]);
  assign imem_addr = pc;

  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_hlt  = (op == OP_HLT);
  assign is_call = (op == OP_CALL);
  assign is_ret  = (op == OP_RET);
  assign is_br   = (op == OP_JMP) | (op[4:2] == 3'b111);
  assign is_bad  = (op == 5'b00011) | (op == 5'b01011)
                 | (op == 5'b10011);
  assign is_bub  = is_bad | is_hlt | is_call | is_ret;

  // Branch condition uses flags of the previous instruction.
  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      op == OP_JMP: taken = 1'b1;
      op == OP_JC:  taken = flag_ex[0];
      op == OP_JNC: taken = ~flag_ex[0];
      op == OP_JZ:  taken = flag_ex[1];
      op == OP_JNZ: taken = ~flag_ex[1];
      default:      taken = 1'b0;
    endcase
  end

`ifdef SEQ_CALL_STACK_EN
  localparam int SP_W = (STK_D > 1) ? $clog2(STK_D) : 1;
  localparam logic [SP_W:0] CNT_MAX = STK_D[SP_W:0];

  logic [PC_W-1:0] stk [STK_D];
  logic [SP_W-1:0] sp, sp_m1;
  logic [SP_W:0]   cnt;
  logic            push, pop;

  assign sp_m1   = sp - 1'b1;
  assign push    = (state == S_DECODE) & is_call;
  assign pop     = (state == S_DECODE) & is_ret
                 & (cnt != '0);
  assign call_tk = is_call;
  assign ret_tk  = is_ret;
  assign ret_pc  = (cnt != '0) ? stk[sp_m1] : '0;
  assign ret_ill = is_ret & (cnt == '0);

  // Circular stack: a push when full overwrites the oldest slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      cnt <= '0;
      for (int i = 0; i < STK_D; i++) stk[i] <= '0;
    end else if (push) begin
      stk[sp] <= pc_inc;
      sp      <= sp + 1'b1;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (pop) begin
      sp  <= sp_m1;
      cnt <= cnt - 1'b1;
    end
  end
`else
  assign call_tk = 1'b0;
  assign ret_tk  = 1'b0;
  assign ret_pc  = '0;
  assign ret_ill = 1'b0;
`endif

  always_comb begin
    d_op   = OP_BUB;
    d_rw   = '0;
    d_imm  = '0;
    d_bsel = 1'b0;
    d_men  = 1'b0;
    d_mrw  = 1'b0;
    d_mmux = 1'b0;
    unique case (1'b1)
      is_bub: begin
      end
      is_br: begin
        d_op  = op;
        d_imm = ir[7:0];
      end
      default: begin
        d_op   = op;
        d_rw   = ir[18:14];
        d_imm  = ir[7:0];
        d_bsel = (op[4:3] == 2'b01);
        d_men  = is_ld | is_st;
        d_mrw  = is_st;
        d_mmux = is_ld;
      end
    endcase
  end

  always_comb begin
    state_n         = state;
    pc_n            = pc;
    wcnt_n          = wcnt;
    imem_req        = 1'b0;
    dec_valid       = 1'b0;
    halted          = 1'b0;
    ill_op          = 1'b0;
    op_dec          = OP_BUB;
    RW_dec          = '0;
    imm_dec         = '0;
    b_sel_imm       = 1'b0;
    mem_en_dec      = 1'b0;
    mem_rw_dec      = 1'b0;
    mem_mux_sel_dec = 1'b0;
    if (state == S_DECODE || state == S_MEM) begin
      op_dec          = d_op;
      RW_dec          = d_rw;
      imm_dec         = d_imm;
      b_sel_imm       = d_bsel;
      mem_en_dec      = d_men;
      mem_rw_dec      = d_mrw;
      mem_mux_sel_dec = d_mmux;
    end
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_n = S_DECODE;
      end
      S_DECODE: begin
        dec_valid = 1'b1;
        ill_op    = is_bad | ret_ill;
        state_n   = S_FETCH;
        unique case (1'b1)
          is_hlt:          state_n = S_HALT;
          taken | call_tk: pc_n    = tgt;
          ret_tk:          pc_n    = ret_pc;
          default:         pc_n    = pc_inc;
        endcase
        if ((is_ld | is_st) && MEM_WAIT != 0) begin
          state_n = S_MEM;
          wcnt_n  = 4'(MEM_WAIT - 1);
        end
      end
      S_MEM: begin
        if (wcnt == '0) state_n = S_FETCH;
        else            wcnt_n  = wcnt - 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      wcnt  <= wcnt_n;
      if (state == S_FETCH && imem_valid) ir <= imem_data;
    end
  end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: directed scenarios plus a randomized
// run against an instruction-level reference model.
module tb_instr_seq_ctrl;

  localparam int MEM_WAIT = 2;
  localparam int STK_D    = 4;
  localparam logic [4:0] BUB = 5'b11000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [23:0] imem_data;
  logic        imem_valid = 1'b0;
  logic [3:0]  flag_ex = 4'd0;
  logic [4:0]  op_dec, RW_dec;
  logic [7:0]  imm_dec;
  logic        b_sel_imm, mem_en_dec, mem_rw_dec;
  logic        mem_mux_sel_dec, dec_valid, halted, ill_op;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] mem [256];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  instr_seq_ctrl #(
    .PC_W(8), .MEM_WAIT(MEM_WAIT), .STK_D(STK_D)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_valid(imem_valid),
    .flag_ex(flag_ex),
    .op_dec(op_dec), .RW_dec(RW_dec), .imm_dec(imm_dec),
    .b_sel_imm(b_sel_imm), .mem_en_dec(mem_en_dec),
    .mem_rw_dec(mem_rw_dec),
    .mem_mux_sel_dec(mem_mux_sel_dec),
    .dec_valid(dec_valid), .halted(halted), .ill_op(ill_op)
  );

  function automatic logic [23:0] mk(
    logic [4:0] op, logic wr, logic [3:0] rd, logic [7:0] imm);
    return {op, wr, rd, 6'b0, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = mk(5'd0, 1'b0, 4'd0, 8'd0);
  endtask

  // Returns at the falling edge of the first FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [33:0] got, exp;
    clear_mem();
    reset = 1'b0;
    imem_valid = 1'b1;
    exp = {1'b1, 8'd0, BUB, 5'd0, 8'd0, 7'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {imem_req, imem_addr, op_dec, RW_dec, imm_dec,
             b_sel_imm, mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
             dec_valid, halted, ill_op};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_state got=%h exp=%h", got, exp);
      end
    end
  endtask

  task automatic test_add();
    logic [7:0] addrs[$];
    logic [23:0] got;
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = mk(5'b00000, 1'b1, 4'd3, 8'd0);
    imem_valid = 1'b1;
    flag_ex = 4'd0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (imem_req) addrs.push_back(imem_addr);
      if (i == 1) begin
        n_tests++;
        if ({op_dec, RW_dec, dec_valid} !== {5'b00000, 5'b10011, 1'b1}) begin
          n_fail++;
          $display("FAIL add_decode got=%b_%b_%b exp=00000_10011_1",
                   op_dec, RW_dec, dec_valid);
        end
      end
      @(negedge clk);
    end
    got = 24'hFFFFFF;
    if (addrs.size() == 3) got = {addrs[0], addrs[1], addrs[2]};
    n_tests++;
    if (got !== 24'h000102) begin
      n_fail++;
      $display("FAIL add_fetch_seq n=%0d got=%h exp=000102",
               addrs.size(), got);
    end
  endtask

  task automatic test_branch();
    clear_mem();
    mem[0] = mk(5'b11110, 1'b1, 4'd5, 8'h40);
    imem_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] exp_pc;
      flag_ex = (k == 0) ? 4'b0010 : 4'b0000;
      exp_pc  = (k == 0) ? 8'h40 : 8'h01;
      do_reset();
      @(negedge clk);
      n_tests++;
      if ({op_dec, RW_dec, dec_valid} !== {5'b11110, 5'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL jz_decode_%0d got=%b_%b_%b exp=11110_00000_1",
                 k, op_dec, RW_dec, dec_valid);
      end
      @(negedge clk);
      n_tests++;
      if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin
        n_fail++;
        $display("FAIL jz_target_%0d got=%h exp=%h", k, imem_addr, exp_pc);
      end
    end
  endtask

  task automatic test_ld();
    logic [13:0] got, exp;
    clear_mem();
    mem[0] = mk(5'b10100, 1'b1, 4'd2, 8'h33);
    imem_valid = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = {mem_en_dec, mem_mux_sel_dec, mem_rw_dec, dec_valid,
             op_dec, RW_dec};
      exp = {3'b110, 1'(k == 0), 5'b10100, 5'b10010};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL ld_hold_%0d got=%b exp=%b", k, got, exp);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({imem_req, imem_addr, mem_en_dec} !== {1'b1, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL ld_refetch got=%b_%h_%b exp=1_01_0",
               imem_req, imem_addr, mem_en_dec);
    end
  endtask

  task automatic test_halt();
    int cyc = 0;
    logic [7:0] last = 8'hFF;
    bit seen = 0;
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = mk(5'b00001, 1'b1, 4'd1, 8'd0);
    mem[5] = mk(5'b10001, 1'b0, 4'd0, 8'd0);
    imem_valid = 1'b1;
    do_reset();
    while (!halted && cyc < 40) begin
      if (imem_req) last = imem_addr;
      if (dec_valid && imem_addr == 8'd5) seen = 1;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (!halted || last !== 8'd5 || !seen) begin
      n_fail++;
      $display("FAIL halt_reach halted=%b last=%h issued=%0d exp=1_05_1",
               halted, last, seen);
    end
    for (int i = 0; i < 10; i++) begin
      imem_valid = 1'($urandom);
      @(negedge clk);
      n_tests++;
      if ({halted, imem_req, dec_valid, op_dec, mem_en_dec}
          !== {1'b1, 1'b0, 1'b0, BUB, 1'b0}) begin
        n_fail++;
        $display("FAIL halt_hold_%0d got=%b%b%b_%b_%b exp=100_11000_0",
                 i, halted, imem_req, dec_valid, op_dec, mem_en_dec);
      end
    end
    imem_valid = 1'b1;
    do_reset();
    n_tests++;
    if ({imem_req, imem_addr, halted} !== {1'b1, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL halt_reset got=%b_%h_%b exp=1_00_0",
               imem_req, imem_addr, halted);
    end
    @(negedge clk);
    n_tests++;
    if (dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_resume got=%b exp=1", dec_valid);
    end
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = mk(5'b01011, 1'b1, 4'd7, 8'h5A);
    mem[1] = mk(5'b10101, 1'b0, 4'd4, 8'h10);
    imem_valid = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if ({imem_req, dec_valid, op_dec, RW_dec, imm_dec, mem_en_dec, ill_op}
          !== {1'b1, 1'b0, BUB, 5'd0, 8'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_%0d got=%b%b_%b_%b_%h exp=10_11000_00000_00",
                 i, imem_req, dec_valid, op_dec, RW_dec, imm_dec);
      end
      @(negedge clk);
    end
    imem_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ill_op, dec_valid, op_dec, RW_dec, imm_dec}
        !== {1'b1, 1'b1, BUB, 5'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL ill_decode got=%b%b_%b_%b_%h exp=11_11000_00000_00",
               ill_op, dec_valid, op_dec, RW_dec, imm_dec);
    end
    @(negedge clk);
    n_tests++;
    if ({ill_op, imem_addr} !== {1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL ill_next got=%b_%h exp=0_01", ill_op, imem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_en_dec, mem_rw_dec, dec_valid} !== 3'b110) begin
      n_fail++;
      $display("FAIL st_mem got=%b%b%b exp=110",
               mem_en_dec, mem_rw_dec, dec_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({op_dec, RW_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
         dec_valid, imem_req, imem_addr}
        !== {BUB, 5'd0, 4'b0000, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_in_mem got=%b_%b_%b%b%b%b_%b_%h exp bubble",
               op_dec, RW_dec, mem_en_dec, mem_rw_dec, mem_mux_sel_dec,
               dec_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef SEQ_CALL_STACK_EN
  task automatic test_callret();
    logic [7:0] addrs[$];
    logic [7:0] exp [11] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50,
                             8'h41, 8'h31, 8'h21, 8'h11, 8'h00};
    int ill_n = 0;
    logic [7:0] ill_at = 8'hFF;
    bit bub_ok = 1;
    clear_mem();
    mem[8'h00] = mk(5'b10010, 1'b1, 4'd1, 8'h10);
    mem[8'h10] = mk(5'b10010, 1'b1, 4'd1, 8'h20);
    mem[8'h20] = mk(5'b10010, 1'b1, 4'd1, 8'h30);
    mem[8'h30] = mk(5'b10010, 1'b1, 4'd1, 8'h40);
    mem[8'h40] = mk(5'b10010, 1'b1, 4'd1, 8'h50);
    mem[8'h50] = mk(5'b10000, 1'b1, 4'd1, 8'h00);
    mem[8'h41] = mk(5'b10000, 1'b1, 4'd1, 8'h00);
    mem[8'h31] = mk(5'b10000, 1'b1, 4'd1, 8'h00);
    mem[8'h21] = mk(5'b10000, 1'b1, 4'd1, 8'h00);
    mem[8'h11] = mk(5'b10000, 1'b1, 4'd1, 8'h00);
    imem_valid = 1'b1;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (imem_req) addrs.push_back(imem_addr);
      if (ill_op) begin
        ill_n++;
        ill_at = imem_addr;
      end
      if (dec_valid && (op_dec !== BUB || RW_dec !== 5'd0)) bub_ok = 0;
      @(negedge clk);
    end
    for (int i = 0; i < 11; i++) begin
      logic [7:0] g;
      g = (i < addrs.size()) ? addrs[i] : 8'hXX;
      n_tests++;
      if (g !== exp[i]) begin
        n_fail++;
        $display("FAIL stack_fetch_%0d got=%h exp=%h", i, g, exp[i]);
      end
    end
    n_tests++;
    if (ill_n != 1 || ill_at !== 8'h11 || !bub_ok) begin
      n_fail++;
      $display("FAIL stack_underflow ill_n=%0d at=%h bub=%0d exp=1_11_1",
               ill_n, ill_at, bub_ok);
    end
  endtask
`else
  task automatic test_callret();
    clear_mem();
    mem[0] = mk(5'b10010, 1'b1, 4'd3, 8'h80);
    mem[1] = mk(5'b10000, 1'b1, 4'd3, 8'h90);
    imem_valid = 1'b1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if ({op_dec, RW_dec, ill_op, dec_valid} !== {BUB, 5'd0, 2'b01}) begin
        n_fail++;
        $display("FAIL callret_off_dec_%0d got=%b_%b_%b%b exp=11000_00000_01",
                 k, op_dec, RW_dec, ill_op, dec_valid);
      end
      @(negedge clk);
      n_tests++;
      if (imem_addr !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL callret_off_pc_%0d got=%h exp=%h",
                 k, imem_addr, 8'(k + 1));
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  m_pc = 8'd0;
    logic [7:0]  stk[$];
    logic [23:0] w;
    logic [4:0]  op;
    logic [7:0]  nxt;
    logic [22:0] e;
    logic [25:0] got;
    bit bad, bub, br, tk, e_ill, v;
    int stalls;
    for (int i = 0; i < 256; i++) begin
      w = 24'($urandom);
      if (w[23:19] == 5'b10001) w[23:19] = 5'b00000;
      mem[i] = w;
    end
    imem_valid = 1'b1;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      w = mem[m_pc];
      stalls = 0;
      v = 0;
      while (!v) begin
        n_tests++;
        if ({imem_req, imem_addr, dec_valid, op_dec, halted}
            !== {1'b1, m_pc, 1'b0, BUB, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_fetch_%0d got=%b_%h_%b_%b exp=1_%h_0_11000",
                   n, imem_req, imem_addr, dec_valid, op_dec, m_pc);
        end
        v = ($urandom_range(0, 3) != 0) || stalls >= 3;
        imem_valid = v;
        flag_ex = 4'($urandom);
        @(negedge clk);
        stalls++;
      end
      flag_ex = 4'($urandom);
      imem_valid = 1'($urandom);
      op  = w[23:19];
      bad = op inside {5'b00011, 5'b01011, 5'b10011};
      bub = bad || (op inside {5'b10000, 5'b10001, 5'b10010});
      br  = op inside {5'b11000, 5'b11100, 5'b11101, 5'b11110, 5'b11111};
      case (op)
        5'b11000: tk = 1;
        5'b11100: tk = flag_ex[0];
        5'b11101: tk = !flag_ex[0];
        5'b11110: tk = flag_ex[1];
        5'b11111: tk = !flag_ex[1];
        default:  tk = 0;
      endcase
      nxt   = tk ? w[7:0] : m_pc + 8'd1;
      e_ill = bad;
`ifdef SEQ_CALL_STACK_EN
      if (op == 5'b10010) begin
        stk.push_back(m_pc + 8'd1);
        if (stk.size() > STK_D) void'(stk.pop_front());
        nxt = w[7:0];
      end else if (op == 5'b10000) begin
        if (stk.size() > 0) nxt = stk.pop_back();
        else begin
          nxt = 8'd0;
          e_ill = 1;
        end
      end
`endif
      e = {bub ? BUB : op,
           (bub || br) ? 5'd0 : w[18:14],
           bub ? 8'd0 : w[7:0],
           1'(!bub && op >= 5'd8 && op <= 5'd15),
           1'(op == 5'b10100 || op == 5'b10101),
           1'(op == 5'b10101),
           1'(op == 5'b10100),
           e_ill};
      got = {op_dec, RW_dec, imm_dec, b_sel_imm, mem_en_dec, mem_rw_dec,
             mem_mux_sel_dec, ill_op, dec_valid, imem_req, halted};
      n_tests++;
      if (got !== {e, 3'b100}) begin
        n_fail++;
        $display("FAIL rnd_decode_%0d pc=%h w=%h got=%h exp=%h",
                 n, m_pc, w, got, {e, 3'b100});
      end
      @(negedge clk);
      if (op == 5'b10100 || op == 5'b10101) begin
        for (int k = 0; k < MEM_WAIT; k++) begin
          got = {op_dec, RW_dec, imm_dec, b_sel_imm, mem_en_dec, mem_rw_dec,
                 mem_mux_sel_dec, ill_op, dec_valid, imem_req, halted};
          n_tests++;
          if (got !== {e, 3'b000}) begin
            n_fail++;
            $display("FAIL rnd_mem_%0d_%0d got=%h exp=%h",
                     n, k, got, {e, 3'b000});
          end
          imem_valid = 1'($urandom);
          @(negedge clk);
        end
      end
      m_pc = nxt;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    test_reset();
    test_add();
    test_branch();
    test_ld();
    test_halt();
    test_stall();
    test_callret();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
